// File: rtl/scan_pkg.sv
// Shared definitions for channel_scan_sequencer: FSM state encoding, default dwell,
// channel count and the enabled-channel search helper.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWELL  = 2'd1,
    SAMPLE = 2'd2
  } scan_state_e;

  localparam int unsigned SCAN_DWELL_DEF = 32'd4;
  localparam int unsigned SCAN_NCH       = 32'd4;

  // Returns {found, index} of the lowest enabled channel at or above 'from'.
  function automatic logic [2:0] first_chan(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = SCAN_NCH - 1; i >= 0; i--) begin
      r = (m[i] && (3'(i) >= from)) ? {1'b1, 2'(i)} : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// 8-bit per-channel dwell counter: load, decrement toward zero, terminal-count flag.
module dwell_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       tc
);

  logic [7:0] count_d;
  logic [7:0] count_q;

  // Next count: load has priority, decrement saturates at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == 8'd0);

endmodule

// File: rtl/channel_scan_sequencer.sv
// Scans the enabled inputs of a downstream 4:1 mux and publishes one snapshot per frame.
// Optional capture path enabled by macro SCAN_CAPTURE_EN (otherwise snap reads 0000).
module channel_scan_sequencer #(
  parameter int unsigned DWELL = scan_pkg::SCAN_DWELL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] mask,
  output logic       S1,
  output logic       S0,
  input  logic       Y,
  output logic       busy,
  output logic [3:0] snap,
  output logic       frame_done
);

  // The DWELL state spans DWELL-1 cycles (count DWELL-2 down to 0), SAMPLE adds one more
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 32'd2);

  scan_pkg::scan_state_e state_d, state_q;
  logic [1:0] sel_d, sel_q;
  logic       busy_d, busy_q;
  logic [3:0] mask_d, mask_q;
  logic       stop_pend_d, stop_pend_q;
  logic       frame_done_d, frame_done_q;
  logic [3:0] snap_d, snap_q;
  logic [3:0] shadow_d, shadow_q;
  logic       cnt_load_s, cnt_dec_s, cnt_tc_s;
  logic [2:0] first_s, next_s;

  assign first_s = scan_pkg::first_chan(mask, 3'd0);
  assign next_s  = scan_pkg::first_chan(mask_q, {1'b0, sel_q} + 3'd1);

`ifndef SCAN_CAPTURE_EN
  logic unused_y_s;
  assign unused_y_s = Y;
`endif

  dwell_counter u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (DWELL_LOAD),
    .dec      (cnt_dec_s),
    .tc       (cnt_tc_s)
  );

  // Next-state, select sequencing and frame publication
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    mask_d       = mask_q;
    stop_pend_d  = stop_pend_q | (busy_q & stop);
    frame_done_d = 1'b0;
`ifdef SCAN_CAPTURE_EN
    snap_d       = snap_q;
    shadow_d     = shadow_q;
`else
    snap_d       = 4'b0000;
    shadow_d     = 4'b0000;
`endif
    cnt_load_s   = 1'b0;
    cnt_dec_s    = 1'b0;
    case (state_q)
      scan_pkg::IDLE: begin
        sel_d       = 2'b00;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
        if (start && first_s[2]) begin
          mask_d     = mask;
          sel_d      = first_s[1:0];
          busy_d     = 1'b1;
          state_d    = scan_pkg::DWELL;
          cnt_load_s = 1'b1;
        end else begin
          state_d = scan_pkg::IDLE;
        end
      end
      scan_pkg::DWELL: begin
        if (cnt_tc_s) begin
          state_d = scan_pkg::SAMPLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      scan_pkg::SAMPLE: begin
`ifdef SCAN_CAPTURE_EN
        shadow_d[sel_q] = Y;
`endif
        if (next_s[2]) begin
          sel_d      = next_s[1:0];
          state_d    = scan_pkg::DWELL;
          cnt_load_s = 1'b1;
        end else begin
          // Frame boundary: publish, then either restart on the fresh mask or go idle
          frame_done_d = 1'b1;
`ifdef SCAN_CAPTURE_EN
          snap_d = shadow_d;
`endif
          shadow_d = 4'b0000;
          if (stop_pend_q || stop || !first_s[2]) begin
            state_d     = scan_pkg::IDLE;
            sel_d       = 2'b00;
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            mask_d     = mask;
            sel_d      = first_s[1:0];
            state_d    = scan_pkg::DWELL;
            cnt_load_s = 1'b1;
          end
        end
      end
      default: begin
        state_d     = scan_pkg::IDLE;
        sel_d       = 2'b00;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
        shadow_d    = 4'b0000;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= scan_pkg::IDLE;
      sel_q        <= 2'b00;
      busy_q       <= 1'b0;
      mask_q       <= 4'b0000;
      stop_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      snap_q       <= 4'b0000;
      shadow_q     <= 4'b0000;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      mask_q       <= mask_d;
      stop_pend_q  <= stop_pend_d;
      frame_done_q <= frame_done_d;
      snap_q       <= snap_d;
      shadow_q     <= shadow_d;
    end
  end

  assign S1         = sel_q[1];
  assign S0         = sel_q[0];
  assign busy       = busy_q;
  assign snap       = snap_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Bench for channel_scan_sequencer: directed vector table plus randomized run
// against a frame-schedule reference model.
module tb_channel_scan_sequencer;

  localparam int DW = 4;
`ifdef SCAN_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [3:0] mask, d_in;
  logic       S1, S0, Y, busy, frame_done;
  logic [3:0] snap;

  int checks = 0;
  int errors = 0;

  // Model state: frame expressed as a list of channels and edges since frame start
  bit         m_busy, m_pend, m_fd;
  int         m_list[4];
  int         m_n, m_t;
  logic [3:0] m_snap, m_shadow;

  typedef struct {
    logic       rst, start, stop;
    logic [3:0] mask, d;
    int         ncyc;
    logic [1:0] sel;
    logic       busy, fd;
    logic [3:0] snap;
  } vec_t;

  vec_t vt[$];

  channel_scan_sequencer #(.DWELL(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mask       (mask),
    .S1         (S1),
    .S0         (S0),
    .Y          (Y),
    .busy       (busy),
    .snap       (snap),
    .frame_done (frame_done)
  );

  assign Y = d_in[{S1, S0}];

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic st, logic sp, logic [3:0] m, logic [3:0] d,
                              int n, logic [1:0] s, logic b, logic f, logic [3:0] sn);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.mask = m; v.d = d; v.ncyc = n;
    v.sel = s; v.busy = b; v.fd = f; v.snap = sn;
    return v;
  endfunction

  task automatic check(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic load_list(logic [3:0] m);
    m_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        m_list[m_n] = i;
        m_n++;
      end
    end
  endtask

  function automatic logic [1:0] exp_sel();
    return m_busy ? 2'(m_list[m_t / DW]) : 2'b00;
  endfunction

  task automatic model_edge();
    int ch;
    if (rst) begin
      m_busy = 1'b0; m_pend = 1'b0; m_fd = 1'b0; m_t = 0;
      m_snap = 4'b0000; m_shadow = 4'b0000;
    end else if (!m_busy) begin
      m_fd = 1'b0;
      if (start && (mask != 4'b0000)) begin
        load_list(mask);
        m_busy = 1'b1; m_t = 0; m_shadow = 4'b0000;
      end
    end else begin
      m_fd   = 1'b0;
      m_pend = m_pend | stop;
      ch     = m_list[m_t / DW];
      m_t++;
      if (CAP && (m_t % DW == 0)) m_shadow[ch] = d_in[ch];
      if (m_t == m_n * DW) begin
        m_fd     = 1'b1;
        m_snap   = m_shadow;
        m_shadow = 4'b0000;
        if (m_pend || (mask == 4'b0000)) begin
          m_busy = 1'b0; m_pend = 1'b0;
        end else begin
          load_list(mask);
          m_t = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("model_sel", {2'b00, S1, S0}, {2'b00, exp_sel()});
    check("model_busy", {3'b000, busy}, {3'b000, m_busy});
    check("model_frame_done", {3'b000, frame_done}, {3'b000, m_fd});
    check("model_snap", snap, m_snap);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mask = 4'hF; d_in = 4'hA;

    // Full scan, then stop during channel 01
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'hF, 4'hA,  2, 2'd0, 1'b0, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 4'hA,  1, 2'd0, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hA,  3, 2'd0, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hA,  1, 2'd1, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hA, 11, 2'd3, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hA,  1, 2'd0, 1'b1, 1'b1, 4'hA));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hA,  1, 2'd0, 1'b1, 1'b0, 4'hA));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 4'hF, 4'hA,  5, 2'd1, 1'b1, 1'b0, 4'hA));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hA,  9, 2'd3, 1'b1, 1'b0, 4'hA));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hA,  1, 2'd0, 1'b0, 1'b1, 4'hA));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hA,  1, 2'd0, 1'b0, 1'b0, 4'hA));
    // Sparse mask 0101
    vt.push_back(mk(1'b0, 1'b1, 1'b0, 4'h5, 4'h5,  1, 2'd0, 1'b1, 1'b0, 4'hA));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'h5, 4'h5,  4, 2'd2, 1'b1, 1'b0, 4'hA));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'h5, 4'h5,  3, 2'd2, 1'b1, 1'b0, 4'hA));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'h5, 4'h5,  1, 2'd0, 1'b1, 1'b1, 4'h5));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'h5, 4'h5,  8, 2'd0, 1'b1, 1'b1, 4'h5));
    // Mask change mid-frame, then single-channel period
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'hF, 4'hF,  1, 2'd0, 1'b0, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 4'hF,  1, 2'd0, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'h2, 4'hF, 15, 2'd3, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'h2, 4'hF,  1, 2'd1, 1'b1, 1'b1, 4'hF));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'h2, 4'hF,  4, 2'd1, 1'b1, 1'b1, 4'h2));
    // Reset during SAMPLE of channel 10
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'hF, 4'hF,  1, 2'd0, 1'b0, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 4'hF,  1, 2'd0, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 11, 2'd2, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'hF, 4'hF,  1, 2'd0, 1'b0, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 20, 2'd0, 1'b0, 1'b0, 4'h0));
    // Ignored starts: empty mask, and start held while busy
    vt.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 4'hF,  2, 2'd0, 1'b0, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 4'hF,  1, 2'd0, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 4'hF,  3, 2'd0, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hF,  1, 2'd1, 1'b1, 1'b0, 4'h0));
    // start together with stop in IDLE: start wins, stop not recorded
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 4'hF, 4'hF,  1, 2'd0, 1'b0, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 4'hF,  1, 2'd0, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 15, 2'd3, 1'b1, 1'b0, 4'h0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 4'hF,  1, 2'd0, 1'b1, 1'b1, 4'hF));

    for (int v = 0; v < vt.size(); v++) begin
      rst = vt[v].rst; start = vt[v].start; stop = vt[v].stop;
      mask = vt[v].mask; d_in = vt[v].d;
      repeat (vt[v].ncyc) cycle();
      check($sformatf("vec%0d_sel", v), {2'b00, S1, S0}, {2'b00, vt[v].sel});
      check($sformatf("vec%0d_busy", v), {3'b000, busy}, {3'b000, vt[v].busy});
      check($sformatf("vec%0d_frame_done", v), {3'b000, frame_done}, {3'b000, vt[v].fd});
      check($sformatf("vec%0d_snap", v), snap, CAP ? vt[v].snap : 4'h0);
    end

    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) mask = 4'($urandom_range(0, 15));
      d_in  = 4'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
